fp_result_collector: RTL and testbench

//  Downstream stage of the 32-bit float adder (1 sign | 6 exp | 25 mantissa).

---
 rtl/fp_result_collector_if.sv | 31 +++
 rtl/fp_result_collector.sv | 96 +++++++++
 tb/tb_fp_result_collector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fp_result_collector_if.sv
// Handshake/status bundle between the float adder, the result collector and its host.
// The master side drives the adder result stream and the consumer ready; the collector is the slave.
interface fp_result_collector_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic [2:0]               qual_lugar_in;
  logic [31:0]              data_in;
  logic [3:0]               status_in;
  logic                     clear_sticky;
  logic                     out_ready;
  logic                     out_valid;
  logic [31:0]              out_data;
  logic [3:0]               out_status;
  logic [$clog2(DEPTH):0]   fill_level;
  logic [3:0]               sticky_flags;
  logic [CNT_W-1:0]         accepted_cnt;
  logic [CNT_W-1:0]         dropped_cnt;

  modport master (
    output qual_lugar_in, data_in, status_in, clear_sticky, out_ready,
    input  out_valid, out_data, out_status, fill_level, sticky_flags,
           accepted_cnt, dropped_cnt
  );

  modport slave (
    input  qual_lugar_in, data_in, status_in, clear_sticky, out_ready,
    output out_valid, out_data, out_status, fill_level, sticky_flags,
           accepted_cnt, dropped_cnt
  );
endinterface

// File: rtl/fp_result_collector.sv
// Captures one {data, status} per completed float-adder pass into a FWFT FIFO,
// with sticky status flags and saturating accepted/dropped counters.
module fp_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clock_100kHz,
  input  logic                 reset,
  fp_result_collector_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_prev_qual;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [3:0]        r_sticky;
  logic [CNT_W-1:0]  r_acc, r_drop;
  logic [31:0]       r_mem_data   [DEPTH];
  logic [3:0]        r_mem_status [DEPTH];

  logic w_cap, w_valid, w_full, w_pop, w_push, w_drop;
  logic [3:0] w_sticky_set;

  // Rising edge into CHECK step: one event per pass even if the step is held.
  assign w_cap   = (bus.qual_lugar_in == 3'd4) && (r_prev_qual != 3'd4);
  assign w_valid = (r_state != S_EMPTY);
  assign w_full  = (r_state == S_FULL);
  assign w_pop   = w_valid && bus.out_ready;
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  always_comb begin
    w_sticky_set = '0;
    if (w_push && (bus.status_in[3:2] == 2'b00))
      w_sticky_set[bus.status_in[1:0]] = 1'b1;
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset && w_push) begin
      r_mem_data[r_wr_ptr]   <= bus.data_in;
      r_mem_status[r_wr_ptr] <= bus.status_in;
    end
  end

  always_ff @(posedge clock_100kHz) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_prev_qual <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_sticky    <= '0;
      r_acc       <= '0;
      r_drop      <= '0;
    end else begin
      r_prev_qual <= bus.qual_lugar_in;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      // A bit set by this cycle's push survives a simultaneous clear.
      r_sticky <= (bus.clear_sticky ? 4'b0000 : r_sticky) | w_sticky_set;
      if (w_push && (r_acc != '1))  r_acc  <= r_acc + 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      case (r_state)
        S_EMPTY:   if (w_push) r_state <= S_PARTIAL;
        S_PARTIAL: begin
          if (w_push && !w_pop && r_fill == FILL_LAST)     r_state <= S_FULL;
          else if (w_pop && !w_push && r_fill == FILL_ONE) r_state <= S_EMPTY;
        end
        S_FULL:    if (w_pop && !w_push) r_state <= S_PARTIAL;
        default:   r_state <= S_EMPTY;
      endcase
    end
  end

  // Head is masked while empty so out_* read zero after reset.
  assign bus.out_valid    = w_valid;
  assign bus.out_data     = w_valid ? r_mem_data[r_rd_ptr]   : 32'd0;
  assign bus.out_status   = w_valid ? r_mem_status[r_rd_ptr] : 4'd0;
  assign bus.fill_level   = r_fill;
  assign bus.sticky_flags = r_sticky;
  assign bus.accepted_cnt = r_acc;
  assign bus.dropped_cnt  = r_drop;
endmodule

// File: tb/tb_fp_result_collector.sv
// Directed vector table for fp_result_collector plus hand sequences for reset and saturation.
module tb_fp_result_collector;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_result_collector_if #(.DEPTH(4), .CNT_W(8)) bus ();
  fp_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
    .clock_100kHz(clk), .reset(rst_n), .bus(bus)
  );

  typedef struct {
    logic [2:0]  q;
    logic [31:0] d;
    logic [3:0]  st;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [2:0]  ef;
    logic [3:0]  esk;
    logic [7:0]  ea;
    logic [7:0]  edr;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] q, input logic [31:0] d, input logic [3:0] st,
                     input logic clr, input logic rdy, input logic ev, input logic [31:0] ed,
                     input logic [3:0] es, input logic [2:0] ef, input logic [3:0] esk,
                     input logic [7:0] ea, input logic [7:0] edr);
    vec_t v;
    v.q = q; v.d = d; v.st = st; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.ef = ef; v.esk = esk; v.ea = ea; v.edr = edr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] q, input logic [31:0] d, input logic [3:0] st,
                       input logic clr, input logic rdy);
    bus.qual_lugar_in = q; bus.data_in = d; bus.status_in = st;
    bus.clear_sticky = clr; bus.out_ready = rdy;
  endtask

  task automatic cap_pass(input logic [31:0] d, input logic [3:0] st, input logic rdy);
    drive(3'd4, d, st, 1'b0, rdy);
    @(posedge clk); #1;
    drive(3'd0, 32'd0, 4'd0, 1'b0, rdy);
    @(posedge clk); #1;
  endtask

  initial begin
    // step sequence, single push
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(2, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(3, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0);
    add(4, 32'h4A00_0000, 0, 0, 0,  1, 32'h4A00_0000, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 0,  1, 32'h4A00_0000, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b0001, 1, 0);
    // step held at 4 for three cycles
    add(4, 32'h1111_1111, 3, 0, 0,  1, 32'h1111_1111, 3, 1, 4'b1001, 2, 0);
    add(4, 32'h2222_2222, 1, 0, 0,  1, 32'h1111_1111, 3, 1, 4'b1001, 2, 0);
    add(4, 32'h2222_2222, 1, 0, 0,  1, 32'h1111_1111, 3, 1, 4'b1001, 2, 0);
    add(0, 0, 0, 0, 0,  1, 32'h1111_1111, 3, 1, 4'b1001, 2, 0);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b1001, 2, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0000, 2, 0);
    // fill to DEPTH, fifth pass dropped
    add(4, 32'hA000_0001, 1, 0, 0,  1, 32'hA000_0001, 1, 1, 4'b0010, 3, 0);
    add(0, 0, 0, 0, 0,  1, 32'hA000_0001, 1, 1, 4'b0010, 3, 0);
    add(4, 32'hA000_0002, 2, 0, 0,  1, 32'hA000_0001, 1, 2, 4'b0110, 4, 0);
    add(0, 0, 0, 0, 0,  1, 32'hA000_0001, 1, 2, 4'b0110, 4, 0);
    add(4, 32'hA000_0003, 3, 0, 0,  1, 32'hA000_0001, 1, 3, 4'b1110, 5, 0);
    add(0, 0, 0, 0, 0,  1, 32'hA000_0001, 1, 3, 4'b1110, 5, 0);
    add(4, 32'hA000_0004, 0, 0, 0,  1, 32'hA000_0001, 1, 4, 4'b1111, 6, 0);
    add(0, 0, 0, 0, 0,  1, 32'hA000_0001, 1, 4, 4'b1111, 6, 0);
    add(4, 32'hA000_0005, 1, 0, 0,  1, 32'hA000_0001, 1, 4, 4'b1111, 6, 1);
    add(0, 0, 0, 0, 0,  1, 32'hA000_0001, 1, 4, 4'b1111, 6, 1);
    // full with cap and pop together, then drain
    add(4, 32'hB000_0006, 2, 0, 1,  1, 32'hA000_0002, 2, 4, 4'b1111, 7, 1);
    add(0, 0, 0, 0, 1,  1, 32'hA000_0003, 3, 3, 4'b1111, 7, 1);
    add(0, 0, 0, 0, 1,  1, 32'hA000_0004, 0, 2, 4'b1111, 7, 1);
    add(0, 0, 0, 0, 1,  1, 32'hB000_0006, 2, 1, 4'b1111, 7, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b1111, 7, 1);
    // clear with a setting push, then out-of-range status
    add(4, 32'hC000_0007, 2, 1, 0,  1, 32'hC000_0007, 2, 1, 4'b0100, 8, 1);
    add(0, 0, 0, 0, 0,  1, 32'hC000_0007, 2, 1, 4'b0100, 8, 1);
    add(4, 32'hD000_0008, 9, 0, 0,  1, 32'hC000_0007, 2, 2, 4'b0100, 9, 1);
    add(0, 0, 0, 0, 1,  1, 32'hD000_0008, 9, 1, 4'b0100, 9, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b0100, 9, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b0100, 9, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.data", bus.out_data, 0);
    chk("rst.fill", bus.fill_level, 0);
    chk("rst.sticky", bus.sticky_flags, 0);
    chk("rst.acc", bus.accepted_cnt, 0);
    chk("rst.drop", bus.dropped_cnt, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].q, vecs[i].d, vecs[i].st, vecs[i].clr, vecs[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), bus.out_valid, vecs[i].ev);
      chk($sformatf("v%0d.data", i), bus.out_data, vecs[i].ed);
      chk($sformatf("v%0d.status", i), bus.out_status, vecs[i].es);
      chk($sformatf("v%0d.fill", i), bus.fill_level, vecs[i].ef);
      chk($sformatf("v%0d.sticky", i), bus.sticky_flags, vecs[i].esk);
      chk($sformatf("v%0d.acc", i), bus.accepted_cnt, vecs[i].ea);
      chk($sformatf("v%0d.drop", i), bus.dropped_cnt, vecs[i].edr);
    end

    // reset mid-stream with three entries queued and a cap in the reset cycle
    cap_pass(32'hE000_0001, 0, 1'b0);
    cap_pass(32'hE000_0002, 1, 1'b0);
    cap_pass(32'hE000_0003, 2, 1'b0);
    chk("mid.fill_pre", bus.fill_level, 3);
    rst_n = 1'b0;
    drive(3'd4, 32'hE000_0004, 3, 0, 0);
    @(posedge clk); #1;
    chk("mid.valid", bus.out_valid, 0);
    chk("mid.fill", bus.fill_level, 0);
    chk("mid.sticky", bus.sticky_flags, 0);
    chk("mid.acc", bus.accepted_cnt, 0);
    chk("mid.drop", bus.dropped_cnt, 0);
    chk("mid.data", bus.out_data, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("mid.fill_post", bus.fill_level, 0);

    // accepted counter saturation with continuous draining
    repeat (260) cap_pass(32'h5555_0000, 0, 1'b1);
    chk("sat.acc", bus.accepted_cnt, 8'hFF);
    chk("sat.fill0", bus.fill_level, 0);
    // dropped counter saturation with a stalled consumer
    repeat (264) cap_pass(32'h6666_0000, 3, 1'b0);
    chk("sat.fill4", bus.fill_level, 4);
    chk("sat.drop", bus.dropped_cnt, 8'hFF);
    chk("sat.acc2", bus.accepted_cnt, 8'hFF);
    chk("sat.head", bus.out_data, 32'h6666_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
